// File: rtl/rot_pkg.sv
// Shared definitions for the barrel rotator family: per-stage shift amounts
// and reference rotate functions used by benches of the forward and inverse rotators.
package rot_pkg;

  localparam int ROT_N      = 64;
  localparam int ROT_LOG2_N = 6;

  typedef logic [0:ROT_N-1]      rot_word_t;
  typedef logic [ROT_LOG2_N-1:0] rot_idx_t;

  // Shift applied by stage s: the stage controlled by k[s] moves by n/2^(s+1).
  function automatic int stage_shift(input int n, input int s);
    return n >> (s + 1);
  endfunction

  // Rotate-left with index 0 as MSB: r[i] = word[(i + k) mod N].
  function automatic rot_word_t rotl(input rot_word_t word, input int k);
    rot_word_t r;
    rot_idx_t  dst;
    rot_idx_t  src;
    r = '0;
    for (int i = 0; i < ROT_N; i++) begin
      dst    = ROT_LOG2_N'(i);
      src    = ROT_LOG2_N'(i + k);
      r[dst] = word[src];
    end
    return r;
  endfunction

  // Rotate-right with index 0 as MSB: r[(i + k) mod N] = word[i].
  function automatic rot_word_t rotr(input rot_word_t word, input int k);
    rot_word_t r;
    rot_idx_t  dst;
    rot_idx_t  src;
    r = '0;
    for (int i = 0; i < ROT_N; i++) begin
      src    = ROT_LOG2_N'(i);
      dst    = ROT_LOG2_N'(i + k);
      r[dst] = word[src];
    end
    return r;
  endfunction

endpackage

// File: rtl/unrot_pipe_chk.sv
// Simulation-only checks on the handshake controls of unrot_pipe.
module unrot_pipe_chk (
  input logic clk,
  input logic rst,
  input logic in_valid,
  input logic out_ready
);

  // Handshake controls must be known whenever the block is out of reset.
  always @(posedge clk) begin
    if (!rst) begin
      assert (!$isunknown(in_valid)) else $error("unrot_pipe: in_valid is X/Z");
      assert (!$isunknown(out_ready)) else $error("unrot_pipe: out_ready is X/Z");
    end
  end

endmodule

// File: rtl/unrot_stage.sv
// One layer of the un-rotator: a conditional fixed rotate-left selected by
// k[stage_number], followed by valid/data/k registers with a local ready term.
module unrot_stage
  import rot_pkg::*;
#(
  parameter int N            = 64,
  parameter int log2_N       = 6,
  parameter int stage_number = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              v_in,
  input  logic [0:N-1]      d_in,
  input  logic [0:log2_N-1] k_in,
  input  logic              ready_in,
  output logic              ready_out,
  output logic              v_out,
  output logic [0:N-1]      d_out,
  output logic [0:log2_N-1] k_out
);

  localparam int shift = stage_shift(N, stage_number);

  logic [0:N-1]      d_next_s;
  logic              v_r;
  logic [0:N-1]      d_r;
  logic [0:log2_N-1] k_r;

  // An empty stage always accepts; a full one only if downstream moves.
  assign ready_out = !v_r || ready_in;

  // Rotate left by this stage's fixed amount when its k bit is set.
  always_comb begin
    d_next_s = d_in;
    if (k_in[stage_number]) begin
      d_next_s = {d_in[shift:N-1], d_in[0:shift-1]};
    end else begin
      d_next_s = d_in;
    end
  end

  // Stage registers: valid follows upstream when ready, payload only on a real word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_r <= 1'b0;
      d_r <= '0;
      k_r <= '0;
    end else if (ready_out) begin
      v_r <= v_in;
      if (v_in) begin
        d_r <= d_next_s;
        k_r <= k_in;
      end
    end
  end

  assign v_out = v_r;
  assign d_out = d_r;
  assign k_out = k_r;

endmodule

// File: rtl/unrot_pipe.sv
// Pipelined inverse barrel rotator: out[i] = in[(i + k) mod N], one registered
// mux layer per shift bit, valid/ready on both sides, k carried alongside.
module unrot_pipe
  import rot_pkg::*;
#(
  parameter int N      = 64,
  parameter int log2_N = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [0:N-1]      in_bits,
  input  logic [0:log2_N-1] in_k,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [0:N-1]      out_bits,
  output logic [0:log2_N-1] out_k
);

  for (genvar s = 0; s < log2_N; s++) begin : g_stage
    logic              v_in_s;
    logic              v_out_s;
    logic              rdy_in_s;
    logic              rdy_out_s;
    logic [0:N-1]      d_in_s;
    logic [0:N-1]      d_out_s;
    logic [0:log2_N-1] k_in_s;
    logic [0:log2_N-1] k_out_s;

    // Stage 0 takes the upstream port; later stages take their predecessor's registers.
    if (s == 0) begin : g_head
      assign v_in_s = in_valid;
      assign d_in_s = in_bits;
      assign k_in_s = in_k;
    end else begin : g_body
      assign v_in_s = g_stage[s-1].v_out_s;
      assign d_in_s = g_stage[s-1].d_out_s;
      assign k_in_s = g_stage[s-1].k_out_s;
    end

    // The last stage sees the downstream ready; others see the next stage's ready.
    if (s == log2_N - 1) begin : g_tail
      assign rdy_in_s = out_ready;
    end else begin : g_feed
      assign rdy_in_s = g_stage[s+1].rdy_out_s;
    end

    unrot_stage #(
      .N           (N),
      .log2_N      (log2_N),
      .stage_number(s)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .v_in     (v_in_s),
      .d_in     (d_in_s),
      .k_in     (k_in_s),
      .ready_in (rdy_in_s),
      .ready_out(rdy_out_s),
      .v_out    (v_out_s),
      .d_out    (d_out_s),
      .k_out    (k_out_s)
    );
  end

  assign in_ready  = g_stage[0].rdy_out_s;
  assign out_valid = g_stage[log2_N-1].v_out_s;
  assign out_bits  = g_stage[log2_N-1].d_out_s;
  assign out_k     = g_stage[log2_N-1].k_out_s;

  unrot_pipe_chk u_chk (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .out_ready(out_ready)
  );

endmodule

// File: doc/unrot_pipe.md
Name: unrot_pipe

Overview:
- Pipelined inverse of the combinational barrel rotator: computes rotate-left of `bits` by `k`, i.e. `out[i] = in[(i + k) mod N]`.
- Output of `rot` fed with the same `k` returns the original word.
- One mux stage per shift bit, each stage registered, valid/ready handshake on both sides.
- Sits in the datapath where rotated words must be restored at full clock rate.

Parameters:
- `N`, 64, word width in bits; must be a power of two.
- `log2_N`, 6, width of the shift amount and number of pipeline stages.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous reset, active-high.
- `in_valid`  in  1  upstream presents a word.
- `in_ready`  out  1  block accepts the word this cycle.
- `in_bits`  in  [0:N-1]  word to un-rotate; index 0 is the MSB.
- `in_k`  in  [0:log2_N-1]  rotate amount; `k[0]` has weight N/2, `k[log2_N-1]` has weight 1.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  downstream accepts the result.
- `out_bits`  out  [0:N-1]  un-rotated word.
- `out_k`  out  [0:log2_N-1]  `k` that travelled with the word, for checking.

Behaviour:
- **Reset (asynchronous, active-high):** all stage valid flags = 0, all data and k registers = 0. Hence `out_valid` = 0, `out_bits` = 0, `out_k` = 0. `in_ready` = 1 combinationally once `rst` is low, since all stages are empty.
- **Reset mid-operation:** every in-flight word is discarded, with no partial output.
- **Stages:** s = 0 .. log2_N-1. Each holds `v[s]`, `d[s]` [0:N-1] and `kk[s]`.
- **Stage s function:** `d_next[i] = kk_in[s] ? d_in[(i + N/2^(s+1)) mod N] : d_in[i]`.
  - Indexing wraps modulo N.
  - Stage 0 consumes `in_bits` / `in_k`; stage s consumes stage s-1's registers.
- **Stall logic:** `ready[s] = !v[s] || ready[s+1]`, with `ready[log2_N] = out_ready`. `in_ready = ready[0]`, a combinational chain.
- **Stage update:** when `ready[s]` is 1, stage s loads `v[s] <= v_in`, where `v_in` is `in_valid` for stage 0 or `v[s-1]` otherwise. Data and k load only when `v_in` = 1; otherwise they hold.
- **Latency and throughput:**
  - A word accepted in cycle t appears on the outputs in cycle t + log2_N when there are no stalls.
  - Throughput is one word per cycle.
- **Output handshake:** `out_valid = v[log2_N-1]`, `out_bits = d[log2_N-1]`, `out_k = kk[log2_N-1]`. While `out_valid` is 1 and `out_ready` is 0, these outputs hold stable.
- **Simultaneous events:**
  - With a full pipe and `out_ready` = 1, the word leaves and a new one enters in the same cycle.
  - Bubbles collapse: an empty stage always accepts.
- **Ordering:** words exit in acceptance order; no drops, no duplicates.
- **Boundaries:**
  - k = 0 is passthrough, delayed by log2_N cycles.
  - k = N-1 equals a rotate-right by 1.
  - The amount is always taken mod N, so no out-of-range case exists.
- **Disallowed inputs:** X on `in_bits` is tolerated, propagated only into data. X on `in_valid` or `out_ready` is illegal; assert on it in simulation.

Decomposition:
- **Shared package `rot_pkg`:**
  - Function `stage_shift(s) = N >> (s+1)`, shared with the forward rotator.
  - Reference model functions `rotr(word,k)` and `rotl(word,k)` for benches.
- **Sub-module `unrot_stage`** (parameters `N`, `log2_N`, `stage_number`):
  - Contains one mux layer plus the valid/data/k registers and the local ready equation.
  - `unrot_pipe` instantiates log2_N of them in a generate loop and wires the output taps.

Test Plan:
- **Passthrough latency:** reset, then `in_bits` = 64'h0123_4567_89AB_CDEF, k = 0, `out_ready` = 1 -> `out_valid` rises exactly 6 cycles after acceptance, with `out_bits` equal to the input and `out_k` = 0.
- **Single-bit wrap:** only index 0 set, k = 1 (`in_k` = 6'b000001) -> only index 63 set. The same word with k = 32 (6'b100000) -> only index 32 set.
- **Round trip:** for all 64 values of k, feed `rot(random, k)` back-to-back -> `out_bits` equals the original word; one result per cycle after the 6-cycle fill.
- **Backpressure:**
  - Stream 10 words and hold `out_ready` = 0 for 8 cycles -> `in_ready` drops after 6 words are accepted, and `out_bits` stays stable.
  - Releasing `out_ready` delivers all 10 words in order, with none lost or duplicated.
- **Bubbles:** alternate `in_valid` 1/0 with `out_ready` = 1 -> `out_valid` follows the same 1/0 pattern delayed by 6 cycles, with correct values.
- **Mid-flight reset:** assert `rst` asynchronously (not on a clock edge) with 4 words in flight -> `out_valid` = 0 and `out_bits` = 0 immediately. After release, a new word with k = 5 yields `rotl(word,5)` after 6 cycles and no stale word appears.
